mm_accumulate_writeback: RTL and testbench

//  Downstream stage of the matrix-multiply product pipeline. Consumes the
//  per-element product stream (valid + 2*W_D result), sums each group of VEC_LEN

---
 rtl/mm_accumulate_writeback_if.sv | 33 +++
 rtl/mm_accumulate_writeback.sv | 166 ++++++++++++++++
 tb/tb_mm_accumulate_writeback.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_accumulate_writeback_if.sv
// Signal bundle for the accumulate/writeback stage: job control, product stream,
// result-memory write port, result FIFO head and status.
interface mm_accumulate_writeback_if #(
    parameter int W_D       = 32,
    parameter int W_MEM_C_A = 9
);
    logic                 start;
    logic [W_D-1:0]       vec_len;
    logic [W_D-1:0]       row_len;
    logic [W_D-1:0]       total_res;
    logic                 in_valid;
    logic [2*W_D-1:0]     in_rslt;
    logic                 mem_we;
    logic [W_MEM_C_A-1:0] mem_addr;
    logic [W_D-1:0]       mem_d;
    logic                 out_valid;
    logic [W_D-1:0]       out_data;
    logic                 out_ready;
    logic [W_D-1:0]       check_sum;
    logic                 busy;
    logic                 done;
    logic                 overflow;

    modport slave (
        input  start, vec_len, row_len, total_res, in_valid, in_rslt, out_ready,
        output mem_we, mem_addr, mem_d, out_valid, out_data, check_sum, busy, done, overflow
    );

    modport master (
        output start, vec_len, row_len, total_res, in_valid, in_rslt, out_ready,
        input  mem_we, mem_addr, mem_d, out_valid, out_data, check_sum, busy, done, overflow
    );
endinterface

// File: rtl/mm_accumulate_writeback.sv
// Sums groups of vec_len products into dot products, writes them to result memory,
// keeps a running check_sum and queues each result in a small valid/ready FIFO.
module mm_accumulate_writeback #(
    parameter int W_D        = 32,
    parameter int W_MEM_C_A  = 9,
    parameter int FIFO_DEPTH = 4
) (
    input logic CLK,
    input logic RST,
    mm_accumulate_writeback_if.slave bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e               state_q, state_d;
    logic [W_D-1:0]       vec_len_q, vec_len_d, row_len_q, row_len_d, total_q, total_d;
    logic [W_D-1:0]       sum_q, sum_d, elem_q, elem_d, res_q, res_d, csum_q, csum_d;
    logic [W_D-1:0]       mem_d_q, mem_d_d;
    logic [W_MEM_C_A-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic                 mem_we_q, mem_we_d, ovf_q, ovf_d;
    logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [W_D-1:0]       fifo_mem [FIFO_DEPTH];
    logic [W_D-1:0]       acc;
    logic                 push, pop, fifo_we, flush, full;
    logic                 unused_hi;

    assign unused_hi = ^bus.in_rslt[2*W_D-1:W_D];
    assign acc       = sum_q + bus.in_rslt[W_D-1:0];
    assign full      = (cnt_q == CW'(FIFO_DEPTH));
    assign pop       = (cnt_q != '0) && bus.out_ready;

    always_comb begin
        state_d    = state_q;
        vec_len_d  = vec_len_q;
        row_len_d  = row_len_q;
        total_d    = total_q;
        sum_d      = sum_q;
        elem_d     = elem_q;
        res_d      = res_q;
        csum_d     = csum_q;
        addr_d     = addr_q;
        ovf_d      = ovf_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_d_d    = mem_d_q;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    vec_len_d = (bus.vec_len == '0) ? W_D'(1) : bus.vec_len;
                    row_len_d = bus.row_len;
                    total_d   = bus.total_res;
                    sum_d     = '0;
                    elem_d    = '0;
                    res_d     = '0;
                    csum_d    = '0;
                    addr_d    = '0;
                    ovf_d     = 1'b0;
                    flush     = 1'b1;
                    state_d   = (bus.total_res == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // res_q reaches total_q on the edge of the final write, so DONE
                // follows one cycle after that write's mem_we.
                if (res_q == total_q) begin
                    state_d = DONE;
                end else if (bus.in_valid) begin
                    if (elem_q != vec_len_q - W_D'(1)) begin
                        sum_d  = acc;
                        elem_d = elem_q + W_D'(1);
                    end else begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = addr_q;
                        mem_d_d    = acc;
                        csum_d     = csum_q + acc;
                        push       = 1'b1;
                        sum_d      = '0;
                        elem_d     = '0;
                        res_d      = res_q + W_D'(1);
                        addr_d     = (W_D'(addr_q) == row_len_q - W_D'(1)) ? '0
                                                                           : addr_q + W_MEM_C_A'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A push into a full FIFO is still accepted when the head leaves this cycle.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        fifo_we = 1'b0;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (pop) rd_d = rd_q + PW'(1);
            if (push && (!full || pop)) begin
                fifo_we = 1'b1;
                wr_d    = wr_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(fifo_we) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            vec_len_q  <= '0;
            row_len_q  <= '0;
            total_q    <= '0;
            sum_q      <= '0;
            elem_q     <= '0;
            res_q      <= '0;
            csum_q     <= '0;
            addr_q     <= '0;
            ovf_q      <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_d_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            vec_len_q  <= vec_len_d;
            row_len_q  <= row_len_d;
            total_q    <= total_d;
            sum_q      <= sum_d;
            elem_q     <= elem_d;
            res_q      <= res_d;
            csum_q     <= csum_d;
            addr_q     <= addr_d;
            ovf_q      <= ovf_d | (push & ~fifo_we);
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_d_q    <= mem_d_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (fifo_we) fifo_mem[wr_q] <= acc;
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_d     = mem_d_q;
    assign bus.out_valid = (cnt_q != '0);
    assign bus.out_data  = (cnt_q != '0) ? fifo_mem[rd_q] : '0;
    assign bus.check_sum = csum_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_mm_accumulate_writeback.sv
// Directed bench for mm_accumulate_writeback: hand-computed dot products,
// address wrap, FIFO overflow/drain, zero-length jobs and mid-job reset.
module tb_mm_accumulate_writeback;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    bit   busy_seen = 0;
    int   wr_cyc_q[$];
    logic [63:0] wr_addr_q[$];
    logic [63:0] wr_data_q[$];
    logic [63:0] pop_q[$];

    mm_accumulate_writeback_if #(.W_D(32), .W_MEM_C_A(9)) bus ();

    mm_accumulate_writeback #(.W_D(32), .W_MEM_C_A(9), .FIFO_DEPTH(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (bus.mem_we) begin
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(64'(bus.mem_addr));
            wr_data_q.push_back(64'(bus.mem_d));
        end
        if (bus.out_valid && bus.out_ready) pop_q.push_back(64'(bus.out_data));
        if (bus.done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (bus.busy) busy_seen = 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_logs();
        wr_cyc_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        pop_q.delete();
        busy_seen = 0;
    endtask

    task automatic do_start(input int vl, input int rl, input int tr);
        bus.start     = 1'b1;
        bus.vec_len   = 32'(vl);
        bus.row_len   = 32'(rl);
        bus.total_res = 32'(tr);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [63:0] p);
        bus.in_valid = 1'b1;
        bus.in_rslt  = p;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0 = done_cnt;
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            #1;
            if (done_cnt != d0) begin
                seen = 1;
                break;
            end
        end
        chk(tag, 64'(seen), 64'd1);
        tick();
    endtask

    initial begin
        logic [63:0] t2_addr [5];
        int sc;
        t2_addr = '{64'd0, 64'd1, 64'd2, 64'd0, 64'd1};
        bus.start = 0; bus.vec_len = 0; bus.row_len = 0; bus.total_res = 0;
        bus.in_valid = 0; bus.in_rslt = 0; bus.out_ready = 0;
        repeat (3) tick();
        chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_check_sum", 64'(bus.check_sum), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        RST = 1'b0;
        tick();

        // vec_len=4, two results 10 and 26
        clear_logs();
        do_start(4, 2, 2);
        for (int i = 1; i <= 8; i++) send(64'(i));
        wait_done("t1_done", 40);
        chk("t1_nwr", 64'(wr_data_q.size()), 64'd2);
        if (wr_data_q.size() == 2) begin
            chk("t1_d0", wr_data_q[0], 64'd10);
            chk("t1_a0", wr_addr_q[0], 64'd0);
            chk("t1_d1", wr_data_q[1], 64'd26);
            chk("t1_a1", wr_addr_q[1], 64'd1);
            chk("t1_done_lat", 64'(done_cyc - wr_cyc_q[1]), 64'd1);
        end
        chk("t1_csum", 64'(bus.check_sum), 64'd36);
        chk("t1_busy_after", 64'(bus.busy), 64'd0);
        chk("t1_head_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_head_data", 64'(bus.out_data), 64'd10);
        bus.out_ready = 1'b1;
        repeat (4) tick();
        chk("t1_npop", 64'(pop_q.size()), 64'd2);
        if (pop_q.size() == 2) begin
            chk("t1_pop0", pop_q[0], 64'd10);
            chk("t1_pop1", pop_q[1], 64'd26);
        end

        // vec_len=0 acts as 1, row_len=3 address wrap
        clear_logs();
        do_start(0, 3, 5);
        for (int i = 5; i <= 9; i++) send(64'(i));
        wait_done("t2_done", 40);
        chk("t2_nwr", 64'(wr_data_q.size()), 64'd5);
        if (wr_data_q.size() == 5)
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("t2_a%0d", i), wr_addr_q[i], t2_addr[i]);
                chk($sformatf("t2_d%0d", i), wr_data_q[i], 64'(i + 5));
            end
        chk("t2_csum", 64'(bus.check_sum), 64'd35);
        chk("t2_npop", 64'(pop_q.size()), 64'd5);

        // modulo wrap, upper half discarded
        clear_logs();
        do_start(2, 1, 1);
        send(64'hFFFF_FFFF_8000_0000);
        send(64'hFFFF_FFFF_8000_0000);
        wait_done("t3_done", 40);
        chk("t3_nwr", 64'(wr_data_q.size()), 64'd1);
        if (wr_data_q.size() == 1) begin
            chk("t3_d", wr_data_q[0], 64'd0);
            chk("t3_a", wr_addr_q[0], 64'd0);
        end
        chk("t3_csum", 64'(bus.check_sum), 64'd0);

        // FIFO overflow with no consumer, then drain
        clear_logs();
        bus.out_ready = 1'b0;
        repeat (2) tick();
        do_start(1, 8, 6);
        for (int i = 1; i <= 6; i++) send(64'(i));
        wait_done("t4_done", 40);
        chk("t4_nwr", 64'(wr_data_q.size()), 64'd6);
        if (wr_data_q.size() == 6) chk("t4_last_addr", wr_addr_q[5], 64'd5);
        chk("t4_overflow", 64'(bus.overflow), 64'd1);
        chk("t4_csum", 64'(bus.check_sum), 64'd21);
        bus.out_ready = 1'b1;
        repeat (8) tick();
        chk("t4_npop", 64'(pop_q.size()), 64'd4);
        if (pop_q.size() == 4)
            for (int i = 0; i < 4; i++) chk($sformatf("t4_pop%0d", i), pop_q[i], 64'(i + 1));
        chk("t4_empty", 64'(bus.out_valid), 64'd0);

        // total_res=0: done one cycle after start, never busy
        clear_logs();
        sc = cyc;
        do_start(4, 2, 0);
        wait_done("t5_done", 10);
        chk("t5_done_lat", 64'(done_cyc - sc), 64'd1);
        chk("t5_busy_seen", 64'(busy_seen), 64'd0);
        chk("t5_overflow_clr", 64'(bus.overflow), 64'd0);

        // start during RUN ignored
        clear_logs();
        do_start(2, 4, 2);
        send(64'd1);
        send(64'd2);
        do_start(1, 4, 1);
        send(64'd3);
        send(64'd4);
        wait_done("t6_done", 40);
        chk("t6_nwr", 64'(wr_data_q.size()), 64'd2);
        if (wr_data_q.size() == 2) begin
            chk("t6_d1", wr_data_q[1], 64'd7);
            chk("t6_a1", wr_addr_q[1], 64'd1);
        end
        chk("t6_csum", 64'(bus.check_sum), 64'd10);

        // reset mid-job
        clear_logs();
        bus.out_ready = 1'b0;
        do_start(1, 4, 8);
        send(64'd1);
        send(64'd2);
        send(64'd3);
        tick();
        chk("t7_pre_csum", 64'(bus.check_sum), 64'd6);
        sc = done_cnt;
        RST = 1'b1;
        tick();
        chk("t7_busy", 64'(bus.busy), 64'd0);
        chk("t7_csum", 64'(bus.check_sum), 64'd0);
        chk("t7_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t7_out_data", 64'(bus.out_data), 64'd0);
        chk("t7_mem_we", 64'(bus.mem_we), 64'd0);
        chk("t7_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("t7_mem_d", 64'(bus.mem_d), 64'd0);
        RST = 1'b0;
        repeat (10) tick();
        chk("t7_no_done", 64'(done_cnt - sc), 64'd0);
        chk("t7_nwr", 64'(wr_data_q.size()), 64'd3);

        clear_logs();
        bus.out_ready = 1'b1;
        do_start(2, 2, 2);
        for (int i = 1; i <= 4; i++) send(64'(i));
        wait_done("t8_done", 40);
        chk("t8_nwr", 64'(wr_data_q.size()), 64'd2);
        if (wr_data_q.size() == 2) chk("t8_d0", wr_data_q[0], 64'd3);
        chk("t8_csum", 64'(bus.check_sum), 64'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
